// File: rtl/spi_mstr.sv
// spi_mstr: SPI master with SCLK idle high, 8/16-bit frames and a selectable slave sample edge.
// Build option: define SPI_MSTR_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
module spi_mstr #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] data_out,
    input  logic        pos_edge,
    input  logic        width8,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done
);
    // state | meaning
    // IDLE  | waiting for wrt, SS_n high, done holds its last value
    // FRONT | SS_n low, SCLK high for half a period, first bit on MOSI
    // SHIFT | N SCLK periods, each a low half followed by a high half
    // BACK  | SCLK high tail of half a period before SS_n releases
    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    localparam int HALF = SCLK_DIV / 2;
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HALF_M1 = HW'(HALF - 1);

    state_t         state;
    logic [HW-1:0]  half_cnt;
    logic [4:0]     bit_cnt;
    logic [15:0]    shift_reg;
    logic           is8;
    logic           pe;
    logic           adv;

    logic [15:0]    load_word;
    logic           load_bit;
    logic [15:0]    next_word;
    logic           next_bit;
    logic [4:0]     n_bits;
    logic           half_tc;

    // The shift register always emits from one fixed end; 8-bit frames are pre-aligned to that end.
`ifdef SPI_MSTR_LSB_FIRST_EN
    assign load_word = width8 ? {8'h00, data_out[7:0]} : data_out;
    assign load_bit  = load_word[0];
    assign next_word = {1'b0, shift_reg[15:1]};
    assign next_bit  = shift_reg[1];
`else
    assign load_word = width8 ? {data_out[7:0], 8'h00} : data_out;
    assign load_bit  = load_word[15];
    assign next_word = {shift_reg[14:0], 1'b0};
    assign next_bit  = shift_reg[14];
`endif

    assign n_bits  = is8 ? 5'd8 : 5'd16;
    assign half_tc = (half_cnt == '0);

    // bit_cnt holds the 1-based index of the SCLK period in progress; adv moves MOSI one clk after a sample edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            done      <= 1'b0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            is8       <= 1'b0;
            pe        <= 1'b0;
            adv       <= 1'b0;
        end else begin
            adv <= 1'b0;
            if (adv) begin
                shift_reg <= next_word;
                MOSI      <= next_bit;
            end
            case (state)
                IDLE: begin
                    if (wrt) begin
                        shift_reg <= load_word;
                        MOSI      <= load_bit;
                        is8       <= width8;
                        pe        <= pos_edge;
                        done      <= 1'b0;
                        SS_n      <= 1'b0;
                        SCLK      <= 1'b1;
                        half_cnt  <= HALF_M1;
                        bit_cnt   <= '0;
                        state     <= FRONT;
                    end
                end
                FRONT: begin
                    if (half_tc) begin
                        SCLK     <= 1'b0;
                        half_cnt <= HALF_M1;
                        bit_cnt  <= 5'd1;
                        adv      <= !pe;
                        state    <= SHIFT;
                    end else begin
                        half_cnt <= half_cnt - HW'(1);
                    end
                end
                SHIFT: begin
                    if (half_tc) begin
                        half_cnt <= HALF_M1;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                            adv  <= pe && (bit_cnt != n_bits);
                        end else if (bit_cnt == n_bits) begin
                            state <= BACK;
                        end else begin
                            SCLK    <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            adv     <= !pe && ((bit_cnt + 5'd1) != n_bits);
                        end
                    end else begin
                        half_cnt <= half_cnt - HW'(1);
                    end
                end
                BACK: begin
                    if (half_tc) begin
                        SS_n      <= 1'b1;
                        done      <= 1'b1;
                        MOSI      <= 1'b0;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        half_cnt <= half_cnt - HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mstr.sv
// tb_spi_mstr: self-checking bench for spi_mstr; decodes MOSI on the slave sample edge and
// compares against a bit-order model. Honours SPI_MSTR_LSB_FIRST_EN like the design.
module tb_spi_mstr;
    localparam int SCLK_DIV = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] data_out = '0;
    logic        pos_edge = 1'b0;
    logic        width8 = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    spi_mstr #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt      (wrt),
        .data_out (data_out),
        .pos_edge (pos_edge),
        .width8   (width8),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bits in the order the slave should see them, first bit ends up in position n-1.
    function automatic logic [15:0] exp_bits(input logic [15:0] word, input logic w8);
        int n = w8 ? 8 : 16;
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) begin
`ifdef SPI_MSTR_LSB_FIRST_EN
            r = {r[14:0], word[i]};
`else
            r = {r[14:0], word[n-1-i]};
`endif
        end
        return r;
    endfunction

    // mode 0: plain frame, 1: extra wrt with altered inputs at bit 5, 2: reset at bit 9.
    task automatic run_frame(input string tag, input logic [15:0] word, input logic w8,
                             input logic pe, input int mode, input int idle);
        int          n = w8 ? 8 : 16;
        logic [15:0] e = exp_bits(word, w8);
        logic [15:0] cap = '0;
        int          ncap = 0;
        int          rises = 0;
        int          low = 0;
        int          cyc = 0;
        logic        psclk = 1'b1;
        logic        done_early = 1'b0;
        logic        injected = 1'b0;
        logic        aborted = 1'b0;
        logic        bad = 1'b0;

        data_out = word;
        width8   = w8;
        pos_edge = pe;
        wrt      = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        chk({tag, "_ss_fall"}, 32'(SS_n), 32'd0);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_first_bit"}, 32'(MOSI), 32'(e[n-1]));

        while (SS_n === 1'b0 && cyc < 2000) begin
            if (wrt) wrt = 1'b0;
            low++;
            if (done !== 1'b0) done_early = 1'b1;
            if (SCLK && !psclk) rises++;
            if (pe ? (SCLK && !psclk) : (!SCLK && psclk)) begin
                cap = {cap[14:0], MOSI};
                ncap++;
            end
            if (mode == 1 && ncap == 5 && !injected) begin
                wrt      = 1'b1;
                data_out = ~word;
                width8   = ~w8;
                pos_edge = ~pe;
                injected = 1'b1;
            end
            if (mode == 2 && ncap == 9) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
                break;
            end
            psclk = SCLK;
            @(negedge clk);
            cyc++;
        end
        wrt = 1'b0;

        if (aborted) begin
            @(negedge clk);
            chk({tag, "_rst_ss"}, 32'(SS_n), 32'd1);
            chk({tag, "_rst_sclk"}, 32'(SCLK), 32'd1);
            chk({tag, "_rst_mosi"}, 32'(MOSI), 32'd0);
            chk({tag, "_rst_done"}, 32'(done), 32'd0);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (SS_n !== 1'b1 || done !== 1'b0 || MOSI !== 1'b0) bad = 1'b1;
            end
            chk({tag, "_rst_quiet"}, 32'(bad), 32'd0);
        end else begin
            chk({tag, "_timeout"}, 32'(cyc < 2000), 32'd1);
            chk({tag, "_ss_low"}, 32'(low), 32'(SCLK_DIV * (n + 1)));
            chk({tag, "_nbits"}, 32'(ncap), 32'(n));
            chk({tag, "_bits"}, 32'(cap), 32'(e));
            chk({tag, "_pulses"}, 32'(rises), 32'(n));
            chk({tag, "_done_early"}, 32'(done_early), 32'd0);
            chk({tag, "_done_rise"}, 32'(done), 32'd1);
            chk({tag, "_mosi_idle"}, 32'(MOSI), 32'd0);
            for (int k = 0; k < idle; k++) begin
                @(negedge clk);
                if (SS_n !== 1'b1 || done !== 1'b1 || MOSI !== 1'b0) bad = 1'b1;
            end
            chk({tag, "_idle_hold"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wrt   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ss", 32'(SS_n), 32'd1);
        chk("reset_sclk", 32'(SCLK), 32'd1);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        wrt   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_ss", 32'(SS_n), 32'd1);

        run_frame("beef16_rise", 16'hBEEF, 1'b0, 1'b1, 0, 3);
        run_frame("beef8_fall", 16'hBEEF, 1'b1, 1'b0, 0, 3);
        run_frame("rewrt_bit5", 16'hC3A1, 1'b0, 1'b1, 1, 2 * SCLK_DIV);
        run_frame("rewrt_bit5_fall", 16'h5A3C, 1'b0, 1'b0, 1, 2 * SCLK_DIV);
        run_frame("rst_bit9", 16'h6D29, 1'b0, 1'b1, 2, 0);
        run_frame("after_rst", 16'hBEEF, 1'b0, 1'b1, 0, 2);
        run_frame("b2b_first", 16'h1234, 1'b0, 1'b1, 0, 0);
        run_frame("b2b_second", 16'hA5A5, 1'b0, 1'b0, 0, 2);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] w = 16'($urandom_range(0, 65535));
            logic        r8 = 1'($urandom_range(0, 1));
            logic        rpe = 1'($urandom_range(0, 1));
            int          ri = int'($urandom_range(0, 3));
            run_frame($sformatf("rand%0d", i), w, r8, rpe, 0, ri);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
